axi4_lite_master: RTL and testbench

//  Single-outstanding AXI4-Lite initiator driving the UART's AXI4-Lite register slave.

---
 rtl/axi4_lite_master.sv | 233 +++++++++++++++++++++++
 tb/tb_axi4_lite_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master.sv
// axi4_lite_master: single-outstanding AXI4-Lite initiator.
// Turns one command into AW/W/B or AR/R handshakes and reports a one-cycle response.
// Optional response timeout with DRAIN state: define AXI_MASTER_TIMEOUT_EN.
module axi4_lite_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    // command / response port
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    timeout,
    // write address channel
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    // write data channel
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    // write response channel
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    // read address channel
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    // read data channel
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

`ifdef AXI_MASTER_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WRESP, S_RD_ADDR, S_RD_DATA, S_DRAIN
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WRESP, S_RD_ADDR, S_RD_DATA
    } state_t;
`endif

    state_t                  state_q;
    logic                    awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
    logic                    aw_done_q, w_done_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;
    logic [2:0]              prot_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic [1:0]              rsp_resp_q;
    logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;

`ifdef AXI_MASTER_TIMEOUT_EN
    logic                    is_write_q;
    logic                    timeout_q;
    logic [15:0]             cnt_q;
    logic                    tmo_hit;
    logic                    done_now;
`else
    logic                    unused_tmo;
`endif

    // Channel handshakes seen this cycle
    assign aw_hs = awvalid_q & awready;
    assign w_hs  = wvalid_q  & wready;
    assign b_hs  = bready_q  & bvalid;
    assign ar_hs = arvalid_q & arready;
    assign r_hs  = rready_q  & rvalid;

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign awprot    = prot_q;
    assign arprot    = prot_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign awvalid   = awvalid_q;
    assign wvalid    = wvalid_q;
    assign arvalid   = arvalid_q;
    assign bready    = bready_q;
    assign rready    = rready_q;

`ifdef AXI_MASTER_TIMEOUT_EN
    assign timeout  = timeout_q;
    assign tmo_hit  = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
    // A response landing on the timeout cycle wins over the timeout
    assign done_now = ((state_q == S_WRESP) && b_hs) || ((state_q == S_RD_DATA) && r_hs);
`else
    assign timeout    = 1'b0;
    assign unused_tmo = ^32'(TIMEOUT_CYCLES);
`endif

    // Transaction FSM with registered channel controls and response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            prot_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
`ifdef AXI_MASTER_TIMEOUT_EN
            is_write_q  <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        wstrb_q <= cmd_wstrb;
                        prot_q  <= cmd_prot;
`ifdef AXI_MASTER_TIMEOUT_EN
                        is_write_q <= cmd_write;
                        cnt_q      <= '0;
`endif
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= S_WR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_ADDR;
                        end
                    end
                end
                S_WR: begin
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    aw_done_q <= aw_done_q | aw_hs;
                    w_done_q  <= w_done_q | w_hs;
                    if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (b_hs) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_resp_q  <= bresp;
                        rsp_rdata_q <= '0;
                        state_q     <= S_IDLE;
                    end
                end
                S_RD_ADDR: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (r_hs) begin
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata;
                        rsp_resp_q  <= rresp;
                        state_q     <= S_IDLE;
                    end
                end
`ifdef AXI_MASTER_TIMEOUT_EN
                S_DRAIN: begin
                    // Finish whatever the slave still owes us, then drop it
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    if (ar_hs) arvalid_q <= 1'b0;
                    if (is_write_q ? (b_hs && !awvalid_q && !wvalid_q)
                                   : (r_hs && !arvalid_q)) begin
                        bready_q <= 1'b0;
                        rready_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
`ifdef AXI_MASTER_TIMEOUT_EN
            // Response watchdog; overrides the normal next state on expiry
            if ((state_q != S_IDLE) && (state_q != S_DRAIN)) begin
                cnt_q <= cnt_q + 16'd1;
                if (tmo_hit && !done_now) begin
                    state_q     <= S_DRAIN;
                    rsp_valid_q <= 1'b1;
                    rsp_resp_q  <= 2'd3;
                    rsp_rdata_q <= '0;
                    timeout_q   <= 1'b1;
                    bready_q    <= is_write_q;
                    rready_q    <= ~is_write_q;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: behavioural AXI4-Lite slave with per-command delays,
// directed vector table, randomized commands, reset-abort and (with the macro) timeout.
module tb_axi4_lite_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        timeout;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    axi4_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout(timeout),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural slave (acts on falling edges) ----------------
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic        b_en;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic [31:0] cfg_rdata;
    bit          aw_fire, w_fire, b_fire, ar_fire, r_fire;
    bit          aw_done, w_done, ar_done;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;

    always @(negedge clk) begin
        if (rst) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            bresp = 0; rresp = 0; rdata = 0;
            aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
            aw_done = 0; w_done = 0; ar_done = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        end else begin
            if (aw_fire) begin aw_done = 1; aw_fire = 0; aw_cnt = 0; awready = 0; end
            else if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; aw_fire = awready; end
            else begin awready = 0; aw_cnt = 0; end
            if (w_fire) begin w_done = 1; w_fire = 0; w_cnt = 0; wready = 0; end
            else if (wvalid) begin wready = (w_cnt >= w_dly); w_cnt++; w_fire = wready; end
            else begin wready = 0; w_cnt = 0; end
            if (ar_fire) begin ar_done = 1; ar_fire = 0; ar_cnt = 0; arready = 0; end
            else if (arvalid) begin arready = (ar_cnt >= ar_dly); ar_cnt++; ar_fire = arready; end
            else begin arready = 0; ar_cnt = 0; end
            if (b_fire) begin bvalid = 0; b_fire = 0; aw_done = 0; w_done = 0; b_cnt = 0; end
            else if (aw_done && w_done && b_en) begin
                if (b_cnt >= b_dly) begin bvalid = 1; bresp = cfg_bresp; end
                else b_cnt++;
                b_fire = bvalid && bready;
            end
            if (r_fire) begin rvalid = 0; r_fire = 0; ar_done = 0; r_cnt = 0; end
            else if (ar_done) begin
                if (r_cnt >= r_dly) begin rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; end
                else r_cnt++;
                r_fire = rvalid && rready;
            end
        end
    end

    // ---------------- monitor: pulse count, valid-high cycles, payload stability ----------------
    int          rsp_cnt = 0, aw_hi = 0, w_hi = 0, ar_hi = 0, stab_err = 0;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [2:0]  exp_prot;

    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid) rsp_cnt++;
            if (awvalid) begin
                aw_hi++;
                if (awaddr !== exp_addr || awprot !== exp_prot) stab_err++;
            end
            if (wvalid) begin
                w_hi++;
                if (wdata !== exp_wdata || wstrb !== exp_wstrb) stab_err++;
            end
            if (arvalid) begin
                ar_hi++;
                if (araddr !== exp_addr || arprot !== exp_prot) stab_err++;
            end
        end
    end

    // ---------------- command vectors and reference model ----------------
    typedef struct {
        bit          wr;
        logic [31:0] addr, data;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          awd, wd, bd, ard, rd;
        logic [1:0]  resp;
        logic [31:0] rdat;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    int done_cmds = 0;

    // Expected outcome from the protocol rules: 1 cycle to present the request,
    // then the slave's wait cycles per channel, 1 cycle per response, 1 to report.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.wr) begin
            r.exp_resp  = v.resp;
            r.exp_rdata = 32'h0;
            r.exp_lat   = 3 + ((v.awd > v.wd) ? v.awd : v.wd) + v.bd;
        end else begin
            r.exp_resp  = v.resp;
            r.exp_rdata = v.rdat;
            r.exp_lat   = 3 + v.ard + v.rd;
        end
        return r;
    endfunction

    // Issue one command from a falling edge and check its full lifecycle
    task automatic do_cmd(input vec_t v);
        int n;
        int lat;
        aw_dly = v.awd; w_dly = v.wd; b_dly = v.bd; ar_dly = v.ard; r_dly = v.rd;
        cfg_bresp = v.resp; cfg_rresp = v.resp; cfg_rdata = v.rdat;
        exp_addr = v.addr; exp_wdata = v.data; exp_wstrb = v.strb; exp_prot = v.prot;
        aw_hi = 0; w_hi = 0; ar_hi = 0; stab_err = 0;
        cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.data;
        cmd_wstrb = v.strb; cmd_prot = v.prot; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("accept_timeout", 64'(n), 64'(0));
        @(negedge clk);
        cmd_valid = 1'b0;
        check("busy_after_accept", 64'(cmd_ready), 64'(0));
        check("req_valids", 64'({awvalid, wvalid, arvalid}), v.wr ? 64'(3'b110) : 64'(3'b001));
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
        check("rsp_latency", 64'(lat), 64'(v.exp_lat));
        check("rsp_resp", 64'(rsp_resp), 64'(v.exp_resp));
        check("rsp_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
        check("ready_with_rsp", 64'(cmd_ready), 64'(1));
        check("aw_high_cycles", 64'(aw_hi), v.wr ? 64'(v.awd + 1) : 64'(0));
        check("w_high_cycles", 64'(w_hi), v.wr ? 64'(v.wd + 1) : 64'(0));
        check("ar_high_cycles", 64'(ar_hi), v.wr ? 64'(0) : 64'(v.ard + 1));
        check("payload_stable", 64'(stab_err), 64'(0));
        check("timeout_flag", 64'(timeout), 64'(0));
        done_cmds++;
    endtask

    vec_t tbl[5];
    vec_t v;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; cmd_prot = '0;
        b_en = 1'b1; aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        cfg_bresp = 0; cfg_rresp = 0; cfg_rdata = 0;
        exp_addr = 0; exp_wdata = 0; exp_wstrb = 0; exp_prot = 0;

        // wr addr data strb prot awd wd bd ard rd resp rdat exp_resp exp_rdata exp_lat
        tbl[0] = '{1, 32'h0000_000C, 32'h0000_0083, 4'hF, 3'd0, 0, 0, 0, 0, 0, 2'd0, 32'h0,         2'd0, 32'h0,         3};
        tbl[1] = '{1, 32'h0000_0010, 32'h0000_A5A5, 4'h3, 3'd2, 4, 0, 0, 0, 0, 2'd1, 32'h0,         2'd1, 32'h0,         7};
        tbl[2] = '{0, 32'h0000_0014, 32'h0,         4'h0, 3'd1, 0, 0, 0, 0, 2, 2'd0, 32'h0000_0060, 2'd0, 32'h0000_0060, 5};
        tbl[3] = '{0, 32'h0000_0018, 32'h0,         4'h0, 3'd5, 0, 0, 0, 0, 0, 2'd2, 32'hDEAD_BEEF, 2'd2, 32'hDEAD_BEEF, 3};
        tbl[4] = '{1, 32'h0000_0004, 32'h1234_5678, 4'h9, 3'd7, 0, 1, 2, 0, 0, 2'd3, 32'h0,         2'd3, 32'h0,         6};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 64'(0));
        check("rst_rsp", 64'({rsp_rdata, rsp_resp, timeout}), 64'(0));
        check("rst_addr", 64'(awaddr), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(cmd_ready), 64'(1));

        // directed table; entries 3->4 run back to back on the response cycle
        for (int i = 0; i < 5; i++) begin
            do_cmd(tbl[i]);
            if (i < 3) repeat (2) @(negedge clk);
        end
        @(negedge clk);
        check("rsp_pulse_count", 64'(rsp_cnt), 64'(done_cmds));
        check("rdata_cleared_by_write", 64'(rsp_rdata), 64'(0));

        // randomized commands with random slave timing and responses
        for (int i = 0; i < 40; i++) begin
            v.wr   = 1'($urandom_range(0, 1));
            v.addr = $urandom & 32'hFFFF_FFFC;
            v.data = $urandom;
            v.strb = 4'($urandom_range(0, 15));
            v.prot = 3'($urandom_range(0, 7));
            v.awd  = $urandom_range(0, 2);
            v.wd   = $urandom_range(0, 2);
            v.bd   = $urandom_range(0, 2);
            v.ard  = $urandom_range(0, 2);
            v.rd   = $urandom_range(0, 2);
            v.resp = 2'($urandom_range(0, 3));
            v.rdat = $urandom;
            do_cmd(model(v));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);
        check("rsp_pulse_count_rand", 64'(rsp_cnt), 64'(done_cmds));

        // reset in the middle of RD_DATA aborts silently
        v = '{0, 32'h0000_0020, 32'h0, 4'h0, 3'd0, 0, 0, 0, 0, 20, 2'd0, 32'h55, 2'd0, 32'h0, 0};
        ar_dly = 0; r_dly = v.rd; cfg_rdata = v.rdat; cfg_rresp = 0;
        exp_addr = v.addr; exp_prot = v.prot;
        cmd_write = 1'b0; cmd_addr = v.addr; cmd_prot = v.prot; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_rready", 64'(rready), 64'(1));
        rst = 1'b1;
        #1;
        check("rst_abort_valids", 64'({arvalid, rready, rsp_valid}), 64'(0));
        check("rst_abort_ready", 64'(cmd_ready), 64'(1));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check("no_rsp_after_abort", 64'(rsp_cnt), 64'(done_cmds));
        check("rst_clears_rsp", 64'({rsp_rdata, rsp_resp}), 64'(0));
        do_cmd(tbl[0]);
        repeat (2) @(negedge clk);

`ifdef AXI_MASTER_TIMEOUT_EN
        // slave withholds bvalid; watchdog fires, then DRAIN waits for the late response
        begin
            int n;
            b_en = 1'b0; aw_dly = 0; w_dly = 0; b_dly = 0; cfg_bresp = 0;
            exp_addr = 32'h0000_0008; exp_wdata = 32'h77; exp_wstrb = 4'hF; exp_prot = 3'd0;
            cmd_write = 1'b1; cmd_addr = exp_addr; cmd_wdata = exp_wdata;
            cmd_wstrb = exp_wstrb; cmd_prot = exp_prot; cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            n = 0;
            while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
            check("tmo_rsp_seen", 64'(n < 50), 64'(1));
            check("tmo_resp", 64'(rsp_resp), 64'(3));
            check("tmo_rdata", 64'(rsp_rdata), 64'(0));
            check("tmo_flag", 64'(timeout), 64'(1));
            done_cmds++;
            repeat (5) @(negedge clk);
            check("drain_busy", 64'({cmd_ready, bready}), 64'(2'b01));
            b_en = 1'b1;
            n = 0;
            while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
            check("drain_done", 64'(cmd_ready), 64'(1));
            check("tmo_sticky", 64'(timeout), 64'(1));
            @(negedge clk);
            check("drain_no_rsp", 64'(rsp_cnt), 64'(done_cmds));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
